// File: rtl/video_sig_gen.sv
// Pixel-timing generator: free-running h/v counters with registered sync,
// active-draw, new-frame strobe and frame counter, all aligned to the counters.
module video_sig_gen #(
    parameter int ACTIVE_H = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int ACTIVE_V = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int FPS      = 60
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;
    localparam bit CFG_OK  = (TOTAL_H <= 2048) && (TOTAL_V <= 1024) && (FPS <= 64) && (FPS >= 1);

    // Sync-end constants carry one extra bit so a window ending exactly at 2048/1024 still compares correctly.
    localparam logic [10:0] H_LAST   = 11'(TOTAL_H - 1);
    localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
    localparam logic [11:0] HS_START = 12'(ACTIVE_H + H_FP);
    localparam logic [11:0] HS_END   = 12'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(TOTAL_V - 1);
    localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
    localparam logic [10:0] VS_START = 11'(ACTIVE_V + V_FP);
    localparam logic [10:0] VS_END   = 11'(ACTIVE_V + V_FP + V_SYNC);
    localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic        line_end;
    logic        nf_next;

    always_comb begin
        line_end = (hcount_out == H_LAST);
        h_next   = line_end ? 11'd0 : hcount_out + 11'd1;
        v_next   = vcount_out;
        if (line_end) begin
            v_next = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
        end
        nf_next = (h_next == H_ACT) && (v_next == V_ACT);
    end

    // NOTE: flags are decoded from the *next* counter values and registered on
    // the same edge as the counters, so flags and counters never skew.
    always_ff @(posedge clk_pixel_in) begin
        assert (CFG_OK) else $error("video_sig_gen: timing parameters out of range");
        if (rst_in) begin
            hcount_out <= H_LAST;
            vcount_out <= V_LAST;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= 6'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            hcount_out <= h_next;
            vcount_out <= v_next;
            ad_out     <= (h_next < H_ACT) && (v_next < V_ACT);
            hs_out     <= ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
            vs_out     <= ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
            nf_out     <= nf_next;
            if (nf_next) begin
                fc_out <= (fc_out == FC_LAST) ? 6'd0 : fc_out + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench: default 720p instance for reset/line timing, tiny instance
// for frame timing, frame-counter wrap and per-cycle flag consistency.
module tb_video_sig_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, rst_s;
    logic [10:0] d_h, s_h;
    logic [9:0]  d_v, s_v;
    logic        d_hs, d_vs, d_ad, d_nf, s_hs, s_vs, s_ad, s_nf;
    logic [5:0]  d_fc, s_fc;

    video_sig_gen dut_d (
        .clk_pixel_in(clk), .rst_in(rst_d),
        .hcount_out(d_h), .vcount_out(d_v), .hs_out(d_hs), .vs_out(d_vs),
        .ad_out(d_ad), .nf_out(d_nf), .fc_out(d_fc)
    );

    video_sig_gen #(
        .ACTIVE_H(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .ACTIVE_V(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FPS(3)
    ) dut_s (
        .clk_pixel_in(clk), .rst_in(rst_s),
        .hcount_out(s_h), .vcount_out(s_v), .hs_out(s_hs), .vs_out(s_vs),
        .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input int h, input int v, input int hs,
                           input int vs, input int ad, input int nf, input int fc);
        check({tag, " h"},  int'(d_h),  h);
        check({tag, " v"},  int'(d_v),  v);
        check({tag, " hs"}, int'(d_hs), hs);
        check({tag, " vs"}, int'(d_vs), vs);
        check({tag, " ad"}, int'(d_ad), ad);
        check({tag, " nf"}, int'(d_nf), nf);
        check({tag, " fc"}, int'(d_fc), fc);
    endtask

    initial begin
        int ad_cnt, hs_cnt, hs_first, ad_last, h_before_wrap;
        int mh, mv, mfc, nf_cnt, last_nf, cyc;
        int exp_fc_seq[4];
        exp_fc_seq = '{1, 2, 0, 1};

        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_d("reset", 1649, 749, 0, 0, 0, 0, 0);
        check("reset small h", int'(s_h), 6);
        check("reset small v", int'(s_v), 4);

        rst_d = 1'b0;
        @(negedge clk);
        check_d("first edge", 0, 0, 0, 0, 1, 0, 0);

        // One full line from (0,0)
        ad_cnt = 0; hs_cnt = 0; hs_first = -1; ad_last = -1; h_before_wrap = -1;
        for (int i = 0; i < 1650; i++) begin
            if (d_ad) begin ad_cnt++; ad_last = int'(d_h); end
            if (d_hs) begin
                if (hs_first < 0) hs_first = int'(d_h);
                hs_cnt++;
            end
            if (i == 1649) h_before_wrap = int'(d_h);
            @(negedge clk);
        end
        check("line ad count", ad_cnt, 1280);
        check("line ad last h", ad_last, 1279);
        check("line hs count", hs_cnt, 40);
        check("line hs start", hs_first, 1390);
        check("line h before wrap", h_before_wrap, 1649);
        check("line wrap h", int'(d_h), 0);
        check("line wrap v", int'(d_v), 1);

        // Mid-frame reset on the default instance at (500,1)
        repeat (500) @(negedge clk);
        check("pre-reset h", int'(d_h), 500);
        rst_d = 1'b1;
        @(negedge clk);
        check_d("mid reset", 1649, 749, 0, 0, 0, 0, 0);
        rst_d = 1'b0;
        @(negedge clk);
        check_d("mid reset release", 0, 0, 0, 0, 1, 0, 0);

        // Small instance: 4 frames with model tracking and flag recompute
        rst_s = 1'b0;
        mh = 6; mv = 4; mfc = 0; nf_cnt = 0; last_nf = -1;
        for (cyc = 1; cyc <= 140; cyc++) begin
            @(negedge clk);
            if (mh == 6) begin
                mh = 0;
                mv = (mv == 4) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            if (mh == 4 && mv == 2) mfc = (mfc == 2) ? 0 : mfc + 1;
            check("small h", int'(s_h), mh);
            check("small v", int'(s_v), mv);
            check("small fc", int'(s_fc), mfc);
            check("small ad", int'(s_ad), int'((s_h < 4) && (s_v < 2)));
            check("small hs", int'(s_hs), int'(s_h == 5));
            check("small vs", int'(s_vs), int'(s_v == 3));
            check("small nf", int'(s_nf), int'((s_h == 4) && (s_v == 2)));
            if (s_nf) begin
                if (nf_cnt < 4) check("small fc at nf", int'(s_fc), exp_fc_seq[nf_cnt]);
                if (last_nf < 0) check("small first nf cycle", cyc, 19);
                else check("small nf period", cyc - last_nf, 35);
                last_nf = cyc;
                nf_cnt++;
            end
        end
        check("small nf count", nf_cnt, 4);

        // Mid-frame reset on the small instance clears a nonzero frame count
        repeat (3) @(negedge clk);
        check("small pre-reset fc", int'(s_fc), 1);
        rst_s = 1'b1;
        @(negedge clk);
        check("small reset h", int'(s_h), 6);
        check("small reset v", int'(s_v), 4);
        check("small reset fc", int'(s_fc), 0);
        check("small reset ad", int'(s_ad), 0);
        rst_s = 1'b0;
        @(negedge clk);
        check("small release h", int'(s_h), 0);
        check("small release v", int'(s_v), 0);
        check("small release ad", int'(s_ad), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Pixel-timing generator directly upstream of the HDMI output stage.
- Produces horizontal/vertical pixel counters, horizontal/vertical sync, active-draw and frame markers on the pixel clock.
- The sync and active-draw outputs drive the TMDS encoders' control and video-enable inputs (blue channel control = {vs, hs}).
- The counters feed the pixel-colour pipeline. Defaults give 1280x720 @ 60 Hz (74.25 MHz pixel clock).

Parameters:
- ACTIVE_H, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- ACTIVE_V, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- FPS, 60, frame-counter modulus

Derived constants:
- TOTAL_H = ACTIVE_H+H_FP+H_SYNC+H_BP (1650)
- TOTAL_V = ACTIVE_V+V_FP+V_SYNC+V_BP (750)

Ports:
- clk_pixel_in  input  1  pixel clock
- rst_in  input  1  reset
- hcount_out  output  11  current pixel column, 0..TOTAL_H-1
- vcount_out  output  10  current line, 0..TOTAL_V-1
- hs_out  output  1  horizontal sync, active high
- vs_out  output  1  vertical sync, active high
- ad_out  output  1  active draw (pixel is visible)
- nf_out  output  1  new-frame strobe, one cycle
- fc_out  output  6  frame count, 0..FPS-1

Behaviour:
- Single clock domain clk_pixel_in. rst_in is synchronous, active-high.
- All outputs are registered. No combinational path from rst_in to the outputs.
- Reset (rst_in high at a rising edge):
  - hcount_out=TOTAL_H-1, vcount_out=TOTAL_V-1
  - hs_out=0, vs_out=0, ad_out=0, nf_out=0, fc_out=0
  - Reset mid-frame takes effect on that edge and discards all position and frame state.
- Counting (each rising edge with rst_in low):
  - hcount_out increments; at TOTAL_H-1 it wraps to 0.
  - vcount_out increments only on the hcount wrap edge; at TOTAL_V-1 (with hcount wrap) it wraps to 0.
  - The first edge after reset release therefore lands on (0,0) with ad_out=1.
- Flag definitions (h,v = values of hcount_out and vcount_out in the same cycle; flags are registered alongside the counters, so no skew between counters and flags):
  - ad_out = (h < ACTIVE_H) && (v < ACTIVE_V)
  - hs_out = (ACTIVE_H+H_FP <= h < ACTIVE_H+H_FP+H_SYNC), i.e. h in [1390,1429]
  - vs_out = (ACTIVE_V+V_FP <= v < ACTIVE_V+V_FP+V_SYNC), i.e. v in [725,729], for every h on those lines
  - nf_out = 1 only in the cycle where h==ACTIVE_H and v==ACTIVE_V (first pixel after the last visible pixel). Exactly one cycle per TOTAL_H*TOTAL_V cycles.
- fc_out:
  - Increments in the same cycle nf_out rises, so fc_out shows the new value while nf_out=1.
  - Wraps FPS-1 -> 0. No other updates.
- Widths:
  - Counters are unsigned, compared at full width.
  - Parameters must satisfy TOTAL_H <= 2048, TOTAL_V <= 1024, FPS <= 64. Out-of-range values are a configuration error, flagged by a simulation-time assertion.
- No enable input: the generator free-runs whenever not in reset.

Test Plan:
- Reset then release: hold rst_in 3 cycles -> outputs (1649,749) with all flags 0 and fc 0; first edge after release -> (0,0), ad=1, hs=0, vs=0, nf=0.
- Line timing: run one line from (0,0):
  - ad=1 for exactly 1280 cycles (h 0..1279)
  - hs=1 for exactly 40 cycles, starting at h=1390
  - h wraps 1649 -> 0 with v 0 -> 1
  - line period 1650 cycles
- Frame timing:
  - vs=1 from (0,725) through (1649,729) = 8250 cycles
  - ad=0 for all v >= 720
  - nf=1 for one cycle at (1280,720); fc 0 -> 1 in that cycle
  - frame period 1,237,500 cycles
- Frame-counter wrap: small params (ACTIVE_H=4, H_FP=1, H_SYNC=1, H_BP=1, ACTIVE_V=2, V_FP=1, V_SYNC=1, V_BP=1, FPS=3) -> nf pulses every 35 cycles; fc sequence 1,2,0,1.
- Reset mid-frame: assert rst_in at (500,300) for 1 cycle -> next cycle (1649,749), flags 0, fc 0; following cycle (0,0), ad=1.
- Consistency check over two full small-param frames: the bench recomputes ad/hs/vs/nf from hcount_out and vcount_out every cycle and requires an exact match, with no one-cycle skew.
